ctrl_unit: RTL and testbench
============================

Name: ctrl_unit

Overview:
- Execute/control stage directly downstream of the instruction ROM. It consumes the 24-bit instruction word presented for the current program counter and drives the ROM's enable, jump_enable and jump_data.
- Holds an 8x8-bit register file, Z/C flags, a return-address stack and a valid/ready output port.
- Retires one instruction per cycle, except OUT, which stalls until the port handshake completes.

Parameters:
- STACK_DEPTH, 4, return-stack entries (1..16).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (0 = reset)
- run  in  1  1 = execute; 0 = pause
- instr  in  24  instruction from ROM; [23:16] opcode, [15:8] operand A, [7:0] operand B
- rom_enable  out  1  advance ROM pc at next edge
- jump_enable  out  1  load ROM pc with jump_data at next edge
- jump_data  out  8  jump target
- out_data  out  8  output-port data
- out_valid  out  1  output-port valid
- out_ready  in  1  output-port ready
- halted  out  1  HALT executed or fault
- fault  out  1  illegal opcode or stack over/underflow
- pc_shadow  out  8  internal mirror of ROM pc (debug)

Behaviour:
- Reset (rst=0 at edge):
  - state=EXEC, all regs=0, Z=C=0, stack pointer=0, pc_shadow=0.
  - out_valid=0, out_data=0, halted=0, fault=0.
  - rom_enable, jump_enable and jump_data are all 0 while rst=0.
- rom_enable, jump_enable and jump_data are combinational from state and instr (Mealy). The ROM responds at the next edge, so the effective latency is 1 instruction per cycle.
- jump_enable and rom_enable are never both 1.
- pc_shadow: increments on rom_enable (saturates at 0xFF, holds), loads jump_data on jump_enable.
- States:
  - EXEC: decode and execute when run=1. When run=0, all strobes are 0 and nothing changes.
  - OUT_WAIT: out_valid=1 and out_data held. On out_valid&out_ready: assert rom_enable for that cycle, drop out_valid at the edge, go to EXEC. run=0 does not retract out_valid; the handshake completes first.
  - HALT: terminal; all strobes 0; halted=1. Left only by reset.
- rA = r[A[2:0]] and rB = r[B[2:0]]; upper operand bits are ignored.
- Opcodes (every non-jump, non-stall opcode asserts rom_enable):
  - 00 NOP.
  - 01 LDI: rA<=B.
  - 02 MOV: rA<=rB.
  - 03 ADD: rA<=(rA+rB) mod 256; C=carry out; Z=(result==0).
  - 04 SUB: rA<=(rA-rB) mod 256; C=borrow; Z=(result==0).
  - ADD/SUB with A==B use the pre-write value for both operands.
  - Flags change only on ADD and SUB.
  - 05 JMP B: jump_enable=1, jump_data=B.
  - 06 JZ B: jump if Z, else rom_enable.
  - 07 JNZ B: jump if !Z, else rom_enable.
  - 08 CALL B: push (pc_shadow+1) mod 256, then jump to B. If the stack is full, it is a fault.
  - 09 RET: pop and jump to the popped value. If the stack is empty, it is a fault.
  - 0A OUT rA: out_data<=rA, out_valid<=1, rom_enable=0, go to OUT_WAIT.
  - FF HALT: rom_enable=0, go to HALT, halted=1.
  - Any other opcode: fault.
- Fault: strobes 0 that cycle, no architectural state change, go to HALT, fault=1 and halted=1, both sticky until reset.
- At pc_shadow=0xFF a non-jump instruction still asserts rom_enable. The ROM and the shadow both stay at 0xFF, so the same instruction re-executes.
- Reset during OUT_WAIT: out_valid falls at that edge; the transfer is lost.

Decomposition:
- Shared package: opcode constants, state encoding, instruction field offsets (OP_HI=23, A_HI=15, B_HI=7).
- One natural sub-module, ret_stack: a STACK_DEPTH x 8 LIFO with push, pop, full and empty outputs.
- Register file and ALU stay inline.

Test Plan:
- Program "LDI r1,5; LDI r2,3; ADD r1,r2; OUT r1; HALT" with out_ready=1 -> out_data=0x08 with one out_valid pulse, Z=0, C=0, halted=1 after 5 instructions.
- "LDI r0,1; SUB r0,r0; JZ 0x10" -> Z=1, jump_enable=1 with jump_data=0x10, pc_shadow=0x10 next cycle. The JNZ variant gives rom_enable instead.
- "LDI r3,0xFF; LDI r4,1; ADD r3,r4" -> r3=0x00, C=1, Z=1.
- CALL 0x20 at pc 0x05, then RET at 0x20 -> push 0x06, jump to 0x06. RET with empty stack -> fault=1, halted=1, strobes 0 thereafter.
- OUT with out_ready=0 for 4 cycles, with run dropped in cycle 2 -> out_valid held 4 cycles, rom_enable=0; on ready, one rom_enable pulse. Assert rst=0 mid-wait in a rerun -> out_valid=0 next edge.
- Opcode 0x7E -> fault=1, no register change. Separately, non-jump code running to 0xFF -> pc_shadow saturates at 0xFF.

Source files
------------

// File: rtl/ctrl_unit_pkg.sv
// ctrl_unit_pkg
//   Shared definitions for the execute/control stage: instruction field
//   offsets, opcode encodings and the FSM state encoding.
package ctrl_unit_pkg;

  // Instruction word layout: [23:16] opcode, [15:8] operand A, [7:0] operand B.
  localparam int OP_HI = 23;
  localparam int A_HI  = 15;
  localparam int B_HI  = 7;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_MOV  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_JMP  = 8'h05;
  localparam logic [7:0] OP_JZ   = 8'h06;
  localparam logic [7:0] OP_JNZ  = 8'h07;
  localparam logic [7:0] OP_CALL = 8'h08;
  localparam logic [7:0] OP_RET  = 8'h09;
  localparam logic [7:0] OP_OUT  = 8'h0A;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    ST_EXEC     = 2'd0,
    ST_OUT_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/ctrl_unit_ret_stack.sv
// ret_stack
//   STACK_DEPTH x 8-bit LIFO holding return addresses.
//   Ports: clk, rst (sync, active-low), push/push_data, pop,
//          top_data (entry that the next pop returns), full, empty.
//   The caller must not push when full or pop when empty.
module ret_stack #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] top_data,
  output logic       full,
  output logic       empty
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [7:0]     mem [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_m1;
  logic           unused_sp_bits;

  assign sp_m1    = sp - SPW'(1);
  assign full     = (sp == SPW'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign top_data = mem[sp_m1[AW-1:0]];
  assign unused_sp_bits = ^sp_m1;

  // Contents are not reset; only the pointer defines what is valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp <= '0;
    end else if (push) begin
      mem[sp[AW-1:0]] <= push_data;
      sp              <= sp + SPW'(1);
    end else if (pop) begin
      sp <= sp_m1;
    end
  end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit
//   Execute/control stage sitting after the instruction ROM. Decodes the
//   24-bit word for the current pc, updates an 8x8 register file, Z/C flags
//   and a return stack, and steers the ROM pc via rom_enable/jump_enable.
//   Ports:
//     clk, rst (sync, active-low), run (0 pauses execution)
//     instr[23:0]      : opcode / operand A / operand B from ROM
//     rom_enable       : ROM pc advances at the next edge
//     jump_enable      : ROM pc loads jump_data at the next edge
//     out_data/out_valid/out_ready : output port (valid/ready)
//     halted, fault    : sticky status
//     pc_shadow        : internal mirror of the ROM pc
//   Handshake: a transfer happens on a cycle where out_valid and out_ready
//   are both 1; out_valid and out_data stay stable until then.
//   The FSM state is held in `state` (state_t) for debug observation.
module ctrl_unit
  import ctrl_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [23:0] instr,
  output logic        rom_enable,
  output logic        jump_enable,
  output logic [7:0]  jump_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halted,
  output logic        fault,
  output logic [7:0]  pc_shadow
);

  state_t     state, next_state;
  logic [7:0] regs [8];
  logic       z_flag, c_flag;

  logic [7:0] op, opa, opb;
  logic [7:0] ra, rb;
  logic [8:0] add_res, sub_res;
  logic       unused_opa_bits;

  logic       reg_we;
  logic [7:0] reg_wdata;
  logic       flag_we, z_next, c_next;
  logic       push, pop, stk_full, stk_empty;
  logic [7:0] stk_top;
  logic       out_load, out_done, fault_set;

  assign op  = instr[OP_HI -: 8];
  assign opa = instr[A_HI -: 8];
  assign opb = instr[B_HI -: 8];
  assign unused_opa_bits = ^opa[7:3];

  assign ra = regs[opa[2:0]];
  assign rb = regs[opb[2:0]];

  // Bit 8 is carry for ADD and borrow for SUB.
  assign add_res = {1'b0, ra} + {1'b0, rb};
  assign sub_res = {1'b0, ra} - {1'b0, rb};

  assign halted = (state == ST_HALT);

  ret_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (pc_shadow + 8'd1),
    .pop       (pop),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    next_state  = state;
    rom_enable  = 1'b0;
    jump_enable = 1'b0;
    jump_data   = 8'h00;
    reg_we      = 1'b0;
    reg_wdata   = 8'h00;
    flag_we     = 1'b0;
    z_next      = 1'b0;
    c_next      = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    out_load    = 1'b0;
    out_done    = 1'b0;
    fault_set   = 1'b0;
    // Strobes are forced low while reset is asserted.
    if (rst) begin
      case (state)
        ST_EXEC: begin
          if (run) begin
            case (op)
              OP_NOP: rom_enable = 1'b1;
              OP_LDI: begin
                rom_enable = 1'b1;
                reg_we     = 1'b1;
                reg_wdata  = opb;
              end
              OP_MOV: begin
                rom_enable = 1'b1;
                reg_we     = 1'b1;
                reg_wdata  = rb;
              end
              OP_ADD: begin
                rom_enable = 1'b1;
                reg_we     = 1'b1;
                reg_wdata  = add_res[7:0];
                flag_we    = 1'b1;
                c_next     = add_res[8];
                z_next     = (add_res[7:0] == 8'h00);
              end
              OP_SUB: begin
                rom_enable = 1'b1;
                reg_we     = 1'b1;
                reg_wdata  = sub_res[7:0];
                flag_we    = 1'b1;
                c_next     = sub_res[8];
                z_next     = (sub_res[7:0] == 8'h00);
              end
              OP_JMP: begin
                jump_enable = 1'b1;
                jump_data   = opb;
              end
              OP_JZ, OP_JNZ: begin
                if (z_flag == (op == OP_JZ)) begin
                  jump_enable = 1'b1;
                  jump_data   = opb;
                end else begin
                  rom_enable = 1'b1;
                end
              end
              OP_CALL: begin
                if (stk_full) begin
                  fault_set  = 1'b1;
                  next_state = ST_HALT;
                end else begin
                  push        = 1'b1;
                  jump_enable = 1'b1;
                  jump_data   = opb;
                end
              end
              OP_RET: begin
                if (stk_empty) begin
                  fault_set  = 1'b1;
                  next_state = ST_HALT;
                end else begin
                  pop         = 1'b1;
                  jump_enable = 1'b1;
                  jump_data   = stk_top;
                end
              end
              OP_OUT: begin
                out_load   = 1'b1;
                next_state = ST_OUT_WAIT;
              end
              OP_HALT: next_state = ST_HALT;
              default: begin
                fault_set  = 1'b1;
                next_state = ST_HALT;
              end
            endcase
          end
        end
        // run is ignored here so a presented transfer always completes.
        ST_OUT_WAIT: begin
          if (out_ready) begin
            rom_enable = 1'b1;
            out_done   = 1'b1;
            next_state = ST_EXEC;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_EXEC;
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      pc_shadow <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      fault     <= 1'b0;
    end else begin
      state <= next_state;
      if (reg_we) regs[opa[2:0]] <= reg_wdata;
      if (flag_we) begin
        z_flag <= z_next;
        c_flag <= c_next;
      end
      // The ROM pc saturates at 0xFF, so the mirror does too.
      if (jump_enable) pc_shadow <= jump_data;
      else if (rom_enable && pc_shadow != 8'hFF) pc_shadow <= pc_shadow + 8'd1;
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= ra;
      end else if (out_done) begin
        out_valid <= 1'b0;
      end
      if (fault_set) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit with a behavioural 256-entry instruction ROM.
module tb_ctrl_unit;

  logic        clk, rst, run, out_ready;
  logic [23:0] instr;
  logic        rom_enable, jump_enable, out_valid, halted, fault;
  logic [7:0]  jump_data, out_data, pc_shadow;

  logic [23:0] rom [256];
  logic [7:0]  rom_pc;
  int          checks, errors;

  ctrl_unit #(.STACK_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .instr       (instr),
    .rom_enable  (rom_enable),
    .jump_enable (jump_enable),
    .jump_data   (jump_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .halted      (halted),
    .fault       (fault),
    .pc_shadow   (pc_shadow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: pc responds to the strobes at the edge, saturating at 0xFF.
  always @(posedge clk) begin
    if (!rst) rom_pc <= 8'h00;
    else if (jump_enable) rom_pc <= jump_data;
    else if (rom_enable && rom_pc != 8'hFF) rom_pc <= rom_pc + 8'd1;
  end
  assign instr = rom[rom_pc];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 24'h000000;
  endtask

  task automatic start();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic run_until_halt(input int max_cycles, input string name);
    int n;
    n = 0;
    while (!halted && n < max_cycles) begin
      tick();
      n++;
    end
    if (!halted) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: halted=%0b after %0d cycles, required 1", name, halted, n);
    end
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 24'h050033;  // JMP 0x33
    rst = 1'b0;
    tick();
    tick();
    checks++; if (rom_enable !== 1'b0) begin errors++; $display("FAIL reset_rom_en got %b exp 0", rom_enable); end
    checks++; if (jump_enable !== 1'b0) begin errors++; $display("FAIL reset_jump_en got %b exp 0", jump_enable); end
    checks++; if (jump_data !== 8'h00) begin errors++; $display("FAIL reset_jump_data got %h exp 00", jump_data); end
    checks++; if ({out_valid, halted, fault} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {out_valid, halted, fault}); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    checks++; if (pc_shadow !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc_shadow); end
    rst = 1'b1;
    #1;
    checks++; if (jump_enable !== 1'b1 || jump_data !== 8'h33) begin errors++; $display("FAIL reset_release_jmp got %b/%h exp 1/33", jump_enable, jump_data); end
  endtask

  task automatic test_basic_program();
    int pulses;
    logic [7:0] got;
    clear_rom();
    rom[0] = 24'h010105;  // LDI r1,5
    rom[1] = 24'h010203;  // LDI r2,3
    rom[2] = 24'h030102;  // ADD r1,r2
    rom[3] = 24'h0A0100;  // OUT r1
    rom[4] = 24'hFF0000;  // HALT
    out_ready = 1'b1;
    run = 1'b1;
    start();
    pulses = 0;
    got = 8'h00;
    for (int i = 0; i < 20 && !halted; i++) begin
      if (out_valid && out_ready) begin
        pulses++;
        got = out_data;
      end
      tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL basic_pulses got %0d exp 1", pulses); end
    checks++; if (got !== 8'h08) begin errors++; $display("FAIL basic_out_data got %h exp 08", got); end
    checks++; if (halted !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL basic_halt got %b%b exp 10", halted, fault); end
    checks++; if ({dut.z_flag, dut.c_flag} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b exp 00", {dut.z_flag, dut.c_flag}); end
    checks++; if (pc_shadow !== 8'h04) begin errors++; $display("FAIL basic_pc got %h exp 04", pc_shadow); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", out_valid); end
    tick();
    checks++; if ({rom_enable, jump_enable} !== 2'b00) begin errors++; $display("FAIL basic_halt_strobes got %b exp 00", {rom_enable, jump_enable}); end
  endtask

  task automatic test_jz_jnz(input bit use_jnz);
    clear_rom();
    rom[0] = 24'h010001;                      // LDI r0,1
    rom[1] = 24'h040000;                      // SUB r0,r0
    rom[2] = use_jnz ? 24'h070010 : 24'h060010;
    rom[3] = 24'hFF0000;
    rom[16] = 24'hFF0000;
    start();
    tick();
    tick();
    checks++; if (dut.z_flag !== 1'b1 || dut.regs[0] !== 8'h00) begin errors++; $display("FAIL jz_sub got z=%b r0=%h exp 1/00", dut.z_flag, dut.regs[0]); end
    if (!use_jnz) begin
      checks++; if ({jump_enable, rom_enable, jump_data} !== {2'b10, 8'h10}) begin errors++; $display("FAIL jz_taken got %b%b/%h exp 10/10", jump_enable, rom_enable, jump_data); end
      tick();
      checks++; if (pc_shadow !== 8'h10) begin errors++; $display("FAIL jz_pc got %h exp 10", pc_shadow); end
    end else begin
      checks++; if ({jump_enable, rom_enable} !== 2'b01) begin errors++; $display("FAIL jnz_fall got %b%b exp 01", jump_enable, rom_enable); end
      tick();
      checks++; if (pc_shadow !== 8'h03) begin errors++; $display("FAIL jnz_pc got %h exp 03", pc_shadow); end
    end
  endtask

  task automatic test_carry();
    clear_rom();
    rom[0] = 24'h0103FF;  // LDI r3,FF
    rom[1] = 24'h010401;  // LDI r4,1
    rom[2] = 24'h030304;  // ADD r3,r4
    rom[3] = 24'hFF0000;
    start();
    run_until_halt(10, "carry");
    checks++; if (dut.regs[3] !== 8'h00 || dut.regs[4] !== 8'h01) begin errors++; $display("FAIL carry_regs got %h/%h exp 00/01", dut.regs[3], dut.regs[4]); end
    checks++; if ({dut.z_flag, dut.c_flag} !== 2'b11) begin errors++; $display("FAIL carry_flags got %b exp 11", {dut.z_flag, dut.c_flag}); end
  endtask

  task automatic test_call_ret();
    clear_rom();
    rom[5]  = 24'h080020;  // CALL 0x20
    rom[32] = 24'h090000;  // RET
    rom[6]  = 24'h090000;  // RET on empty stack
    start();
    repeat (5) tick();
    checks++; if ({jump_enable, rom_enable, jump_data} !== {2'b10, 8'h20}) begin errors++; $display("FAIL call_jump got %b%b/%h exp 10/20", jump_enable, rom_enable, jump_data); end
    tick();
    checks++; if (pc_shadow !== 8'h20 || jump_enable !== 1'b1 || jump_data !== 8'h06) begin errors++; $display("FAIL ret_jump got pc=%h je=%b jd=%h exp 20/1/06", pc_shadow, jump_enable, jump_data); end
    tick();
    checks++; if (pc_shadow !== 8'h06 || {jump_enable, rom_enable} !== 2'b00) begin errors++; $display("FAIL ret_empty got pc=%h strobes=%b exp 06/00", pc_shadow, {jump_enable, rom_enable}); end
    tick();
    checks++; if ({fault, halted} !== 2'b11) begin errors++; $display("FAIL ret_fault got %b exp 11", {fault, halted}); end
    tick();
    checks++; if ({jump_enable, rom_enable} !== 2'b00 || pc_shadow !== 8'h06) begin errors++; $display("FAIL ret_after got %b pc=%h exp 00/06", {jump_enable, rom_enable}, pc_shadow); end
  endtask

  task automatic test_stack_full();
    clear_rom();
    rom[0] = 24'h080000;  // CALL 0x00, repeated
    start();
    repeat (4) tick();
    checks++; if ({jump_enable, rom_enable} !== 2'b00) begin errors++; $display("FAIL full_strobes got %b exp 00", {jump_enable, rom_enable}); end
    tick();
    checks++; if ({fault, halted} !== 2'b11) begin errors++; $display("FAIL full_fault got %b exp 11", {fault, halted}); end
  endtask

  task automatic test_out_stall();
    int valid_n, en_n;
    clear_rom();
    rom[0] = 24'h0105A5;  // LDI r5,A5
    rom[1] = 24'h0A0500;  // OUT r5
    rom[2] = 24'hFF0000;
    out_ready = 1'b0;
    run = 1'b1;
    start();
    tick();
    tick();
    valid_n = 0;
    en_n = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin run = 1'b0; #1; end
      if (out_valid === 1'b1 && out_data === 8'hA5) valid_n++;
      if (rom_enable !== 1'b0 || jump_enable !== 1'b0) en_n++;
      tick();
    end
    checks++; if (valid_n != 4) begin errors++; $display("FAIL stall_valid got %0d exp 4", valid_n); end
    checks++; if (en_n != 0) begin errors++; $display("FAIL stall_strobes got %0d exp 0", en_n); end
    run = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if ({rom_enable, jump_enable} !== 2'b10) begin errors++; $display("FAIL stall_release got %b exp 10", {rom_enable, jump_enable}); end
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || pc_shadow !== 8'h02) begin errors++; $display("FAIL stall_done got v=%b pc=%h exp 0/02", out_valid, pc_shadow); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL stall_halt got %b exp 1", halted); end
    // Rerun, reset in the middle of the wait.
    start();
    tick();
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_wait_pre got %b exp 1", out_valid); end
    rst = 1'b0;
    tick();
    checks++; if ({out_valid, rom_enable} !== 2'b00) begin errors++; $display("FAIL rst_wait_drop got %b exp 00", {out_valid, rom_enable}); end
    rst = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_illegal();
    clear_rom();
    rom[0] = 24'h010133;  // LDI r1,33
    rom[1] = 24'h7E0144;  // illegal
    start();
    tick();
    checks++; if ({rom_enable, jump_enable} !== 2'b00) begin errors++; $display("FAIL illegal_strobes got %b exp 00", {rom_enable, jump_enable}); end
    tick();
    checks++; if ({fault, halted} !== 2'b11) begin errors++; $display("FAIL illegal_fault got %b exp 11", {fault, halted}); end
    checks++; if (dut.regs[1] !== 8'h33 || pc_shadow !== 8'h01) begin errors++; $display("FAIL illegal_state got r1=%h pc=%h exp 33/01", dut.regs[1], pc_shadow); end
  endtask

  task automatic test_saturate();
    clear_rom();
    start();
    repeat (255) tick();
    checks++; if (pc_shadow !== 8'hFF || rom_enable !== 1'b1) begin errors++; $display("FAIL sat_reach got pc=%h en=%b exp FF/1", pc_shadow, rom_enable); end
    repeat (10) tick();
    checks++; if (pc_shadow !== 8'hFF || halted !== 1'b0) begin errors++; $display("FAIL sat_hold got pc=%h h=%b exp FF/0", pc_shadow, halted); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    run = 1'b1;
    out_ready = 1'b1;
    clear_rom();
    @(negedge clk);
    test_reset();
    test_basic_program();
    test_jz_jnz(1'b0);
    test_jz_jnz(1'b1);
    test_carry();
    test_call_ret();
    test_stack_full();
    test_out_stall();
    test_illegal();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
